// File: rtl/cordic_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Package     : cordic_pkg                                                   |
// | Description : Shared types and constants for the iterative CORDIC engine:  |
// |               mode encodings, FSM state enum, Q2.30 atan/atanh tables and  |
// |               the hyperbolic repeat-step predicate.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cordic_pkg;

  typedef enum logic [1:0] {
    MODE_CIRCULAR   = 2'b00,
    MODE_LINEAR     = 2'b01,
    MODE_HYPERBOLIC = 2'b10,
    MODE_ILLEGAL    = 2'b11
  } cordic_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } cordic_state_e;

  // Iteration index width: covers shifts 0..31 plus headroom.
  localparam int IDX_W = 6;

  // atan(2^-i) in Q2.30, round-to-nearest. From i=10 on atan(2^-i) == 2^-i
  // to within half an LSB, so those entries are generated.
  function automatic logic [31:0] atan_q30(input logic [IDX_W-1:0] i);
    logic [31:0] v;
    case (i)
      6'd0:  v = 32'd843314857;
      6'd1:  v = 32'd497837829;
      6'd2:  v = 32'd263043837;
      6'd3:  v = 32'd133525159;
      6'd4:  v = 32'd67021687;
      6'd5:  v = 32'd33543516;
      6'd6:  v = 32'd16775851;
      6'd7:  v = 32'd8388437;
      6'd8:  v = 32'd4194283;
      6'd9:  v = 32'd2097149;
      6'd31: v = 32'd0;
      default: v = (i <= 6'd30) ? (32'd1 << (6'd30 - i)) : 32'd0;
    endcase
    return v;
  endfunction

  // atanh(2^-i) in Q2.30, round-to-nearest. Entry 0 is never used
  // (hyperbolic schedule starts at i=1) and is tied to zero.
  function automatic logic [31:0] atanh_q30(input logic [IDX_W-1:0] i);
    logic [31:0] v;
    case (i)
      6'd0:  v = 32'd0;
      6'd1:  v = 32'd589812981;
      6'd2:  v = 32'd274247419;
      6'd3:  v = 32'd134923406;
      6'd4:  v = 32'd67196451;
      6'd5:  v = 32'd33565361;
      6'd6:  v = 32'd16778582;
      6'd7:  v = 32'd8388779;
      6'd8:  v = 32'd4194325;
      6'd9:  v = 32'd2097155;
      6'd31: v = 32'd1;
      default: v = (i <= 6'd30) ? (32'd1 << (6'd30 - i)) : 32'd0;
    endcase
    return v;
  endfunction

  // Hyperbolic steps k = 4, 13, 40 (k' = 3k+1) are executed twice so the
  // hyperbolic iteration converges.
  function automatic logic hyp_repeat(input logic [IDX_W-1:0] i);
    return (i == 6'd4) || (i == 6'd13) || (i == 6'd40);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_angle_lut.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : cordic_angle_lut                                             |
// | Description : Combinational elementary-angle lookup e(i) for the selected  |
// |               CORDIC mode, scaled to Q.FRAC and widened to WIDTH+2 bits.   |
// | Ports       : mode_i  - coordinate system (circular/linear/hyperbolic)     |
// |               idx_i   - iteration index i                                  |
// |               e_o     - e(i) in Q.FRAC, WIDTH+2 bits, non-negative         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cordic_angle_lut
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  cordic_mode_e             mode_i,
  input  logic [IDX_W-1:0]         idx_i,
  output logic signed [WIDTH+1:0]  e_o
);

  localparam int EW = WIDTH + 2;
  localparam int SH = 30 - FRAC;
  localparam logic [EW-1:0] ONE_FRAC = EW'(1) << FRAC;

  logic [31:0]   w_c;
  logic [31:0]   w_rnd;
  logic [EW-1:0] w_tab;
  logic [EW-1:0] w_lin;

  assign w_c = (mode_i == MODE_HYPERBOLIC) ? atanh_q30(idx_i) : atan_q30(idx_i);

  // Q2.30 -> Q.FRAC with round-half-up. Table entries are positive and
  // below 2^30, so the 33-bit sum never overflows.
  generate
    if (SH > 0) begin : g_round
      logic [32:0] w_sum;
      assign w_sum = {1'b0, w_c} + (33'd1 << (SH - 1));
      assign w_rnd = 32'(w_sum >> SH);
    end else begin : g_exact
      assign w_rnd = w_c;
    end
  endgenerate

  assign w_tab = EW'(w_rnd);
  // Linear e(i) = 2^-i exactly; the single set bit shifts out to zero for i > FRAC.
  assign w_lin = ONE_FRAC >> idx_i;

  assign e_o = (mode_i == MODE_LINEAR) ? $signed(w_lin) : $signed(w_tab);

endmodule
`default_nettype wire

// File: rtl/cordic_iter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : cordic_iter                                                  |
// | Description : Iterative CORDIC engine, one micro-rotation per clock.       |
// |               Circular / linear / hyperbolic, rotation or vectoring, with  |
// |               valid/ready handshakes on input and output.                  |
// | Ports       : clk_i, rstn_i (async active-low)                             |
// |               valid_i/ready_o, mode_i, rotational_i, x_i/y_i/z_i  (input)  |
// |               valid_o/ready_i, x_o/y_o/z_o, err_o                 (output) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int ITERS = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       mode_i,
  input  logic             rotational_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] z_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] z_o,
  output logic             err_o
);

  localparam int DW = WIDTH + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERS - 1);

  cordic_state_e          state_q, state_d;
  cordic_mode_e           mode_q;
  logic                   rot_q;
  logic signed [DW-1:0]   x_q, y_q, z_q;
  logic signed [DW-1:0]   x_d, y_d, z_d;
  logic [IDX_W-1:0]       idx_q;
  logic                   rep_q;
  logic [WIDTH-1:0]       xo_q, yo_q, zo_q;
  logic                   err_q;

  logic                   w_accept;
  logic                   w_rep_now;
  logic                   w_last;
  logic                   w_sigma_pos;
  logic signed [DW-1:0]   w_xs, w_ys, w_e;

  // Clamp a WIDTH+2 internal value into the signed WIDTH output range.
  function automatic logic [WIDTH-1:0] sat(input logic signed [DW-1:0] v);
    logic [2:0] top;
    top = v[DW-1:WIDTH-1];
    if (top == 3'b000 || top == 3'b111) return v[WIDTH-1:0];
    else if (v[DW-1])                   return {1'b1, {(WIDTH-1){1'b0}}};
    else                                return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = CALC;
      CALC:    if (w_last)  state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
  end

  // ------------------------------------------------------- schedule ----
  assign w_accept  = valid_i && (state_q == IDLE);
  // First pass of a repeated hyperbolic step: hold the index, set the flag.
  assign w_rep_now = (mode_q == MODE_HYPERBOLIC) && hyp_repeat(idx_q) && !rep_q;

  always_comb begin
    w_last = 1'b0;
    case (mode_q)
      MODE_ILLEGAL: w_last = 1'b1;
      default:      w_last = (idx_q == LAST_IDX) && !w_rep_now;
    endcase
  end

  // ------------------------------------------------------- datapath ----
  cordic_angle_lut #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_lut (
    .mode_i (mode_q),
    .idx_i  (idx_q),
    .e_o    (w_e)
  );

  assign w_xs        = x_q >>> idx_q;
  assign w_ys        = y_q >>> idx_q;
  // Rotation drives z to zero, vectoring drives y to zero.
  assign w_sigma_pos = rot_q ? ~z_q[DW-1] : y_q[DW-1];

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    case (mode_q)
      MODE_CIRCULAR:   x_d = w_sigma_pos ? (x_q - w_ys) : (x_q + w_ys);
      MODE_HYPERBOLIC: x_d = w_sigma_pos ? (x_q + w_ys) : (x_q - w_ys);
      default:         x_d = x_q;
    endcase
    if (mode_q != MODE_ILLEGAL) begin
      y_d = w_sigma_pos ? (y_q + w_xs) : (y_q - w_xs);
      z_d = w_sigma_pos ? (z_q - w_e)  : (z_q + w_e);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_q <= MODE_CIRCULAR;
      rot_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      idx_q  <= '0;
      rep_q  <= 1'b0;
    end else if (w_accept) begin
      mode_q <= cordic_mode_e'(mode_i);
      rot_q  <= rotational_i;
      x_q    <= {{2{x_i[WIDTH-1]}}, x_i};
      y_q    <= {{2{y_i[WIDTH-1]}}, y_i};
      z_q    <= {{2{z_i[WIDTH-1]}}, z_i};
      idx_q  <= (mode_i == MODE_HYPERBOLIC) ? IDX_W'(1) : IDX_W'(0);
      rep_q  <= 1'b0;
    end else if (state_q == CALC) begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      if (w_rep_now) begin
        rep_q <= 1'b1;
      end else begin
        rep_q <= 1'b0;
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  // Results captured (and saturated) from the final micro-rotation.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      xo_q  <= '0;
      yo_q  <= '0;
      zo_q  <= '0;
      err_q <= 1'b0;
    end else if ((state_q == CALC) && w_last) begin
      xo_q  <= sat(x_d);
      yo_q  <= sat(y_d);
      zo_q  <= sat(z_d);
      err_q <= (mode_q == MODE_ILLEGAL);
    end
  end

  assign x_o   = xo_q;
  assign y_o   = yo_q;
  assign z_o   = zo_q;
  assign err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_cordic_iter                                               |
// | Description : Directed self-checking bench for cordic_iter                 |
// |               (WIDTH=32, FRAC=16, ITERS=16) with hand-computed results.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cordic_iter;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int ITERS = 16;

  logic              clk_i        = 1'b0;
  logic              rstn_i       = 1'b0;
  logic              valid_i      = 1'b0;
  logic              ready_i      = 1'b0;
  logic              rotational_i = 1'b0;
  logic [1:0]        mode_i       = 2'b00;
  logic [WIDTH-1:0]  x_i          = '0;
  logic [WIDTH-1:0]  y_i          = '0;
  logic [WIDTH-1:0]  z_i          = '0;
  logic              ready_o;
  logic              valid_o;
  logic              err_o;
  logic [WIDTH-1:0]  x_o;
  logic [WIDTH-1:0]  y_o;
  logic [WIDTH-1:0]  z_o;

  int n_vec = 0;
  int n_err = 0;
  int lat;

  always #5 clk_i = ~clk_i;

  cordic_iter #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ITERS (ITERS)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .mode_i       (mode_i),
    .rotational_i (rotational_i),
    .x_i          (x_i),
    .y_i          (y_i),
    .z_i          (z_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .x_o          (x_o),
    .y_o          (y_o),
    .z_o          (z_o),
    .err_o        (err_o)
  );

  task automatic check(input string tag, input longint obs, input longint exp, input int tol);
    longint d;
    n_vec++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d +/- %0d", tag, obs, obs, exp, tol);
    end
  endtask

  // Issue one operation, then scramble mode/rotational to prove they were latched.
  // Returns the number of clock edges from the accept edge to valid_o.
  task automatic run_op(input logic [1:0] m, input logic r,
                        input logic [31:0] xa, input logic [31:0] ya, input logic [31:0] za,
                        output int l);
    @(negedge clk_i);
    mode_i = m; rotational_i = r; x_i = xa; y_i = ya; z_i = za; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; mode_i = ~m; rotational_i = ~r;
    x_i = 32'h1234_5678; y_i = 32'h0BAD_F00D; z_i = 32'h0000_7777;
    l = 0;
    while (!valid_o && l < 100) begin
      @(posedge clk_i); #1;
      l++;
    end
  endtask

  task automatic pop(input string tag);
    @(negedge clk_i);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check({tag, "_valid_drop"}, valid_o, 0, 0);
    check({tag, "_ready_rise"}, ready_o, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", ready_o, 1, 0);
    check("rst_valid", valid_o, 0, 0);
    check("rst_err",   err_o,   0, 0);
    check("rst_x", $signed(x_o), 0, 0);
    check("rst_y", $signed(y_o), 0, 0);
    check("rst_z", $signed(z_o), 0, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // ---------------- circular rotation: (1/K, 0) by pi/4 -> (cos, sin) = 0xB505
    run_op(2'b00, 1'b1, 32'h9B75, 32'h0, 32'hC910, lat);
    check("circ_rot_lat", lat, 16, 0);
    check("circ_rot_x", $signed(x_o), 46341, 6);
    check("circ_rot_y", $signed(y_o), 46341, 6);
    check("circ_rot_z", $signed(z_o), 0, 4);
    check("circ_rot_err", err_o, 0, 0);
    pop("circ_rot");

    // ---------------- circular vectoring: (1,1) -> angle pi/4, |v| = K*sqrt2 = 2.32887
    run_op(2'b00, 1'b0, 32'h10000, 32'h10000, 32'h0, lat);
    check("circ_vec_lat", lat, 16, 0);
    check("circ_vec_z", $signed(z_o), 51472, 4);
    check("circ_vec_x", $signed(x_o), 152625, 8);
    check("circ_vec_y", $signed(y_o), 0, 4);
    pop("circ_vec");

    // ---------------- linear rotation: y = 2 * 1.5 = 3
    run_op(2'b01, 1'b1, 32'h20000, 32'h0, 32'h18000, lat);
    check("lin_rot_lat", lat, 16, 0);
    check("lin_rot_y", $signed(y_o), 196608, 4);
    check("lin_rot_x", $signed(x_o), 131072, 0);
    pop("lin_rot");

    // ---------------- linear vectoring: z = 2 / 4 = 0.5
    run_op(2'b01, 1'b0, 32'h40000, 32'h20000, 32'h0, lat);
    check("lin_vec_lat", lat, 16, 0);
    check("lin_vec_z", $signed(z_o), 32768, 4);
    check("lin_vec_x", $signed(x_o), 262144, 0);
    pop("lin_vec");

    // ---------------- hyperbolic rotation: cosh 0.5 = 1.12763, sinh 0.5 = 0.52110
    run_op(2'b10, 1'b1, 32'h1351E, 32'h0, 32'h8000, lat);
    check("hyp_rot_lat", lat, 17, 0);
    check("hyp_rot_x", $signed(x_o), 73900, 5);
    check("hyp_rot_y", $signed(y_o), 34151, 5);
    check("hyp_rot_z", $signed(z_o), 0, 4);
    pop("hyp_rot");

    // ---------------- saturation at both rails (linear rotation, y += x*1)
    run_op(2'b01, 1'b1, 32'h7FFF0000, 32'h7FFF0000, 32'h10000, lat);
    check("sat_pos_y", $signed(y_o), 64'sd2147483647, 0);
    check("sat_pos_x", $signed(x_o), 64'sd2147418112, 0);
    pop("sat_pos");
    run_op(2'b01, 1'b1, 32'h80000000, 32'h80000000, 32'h10000, lat);
    check("sat_neg_y", $signed(y_o), -64'sd2147483648, 0);
    pop("sat_neg");

    // ---------------- backpressure: hold ready_i low, offer new operands
    run_op(2'b01, 1'b1, 32'h20000, 32'h0, 32'h18000, lat);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      valid_i = 1'b1; mode_i = 2'b11; x_i = 32'd5; y_i = 32'd6; z_i = 32'd7;
      @(posedge clk_i); #1;
      check("bp_valid", valid_o, 1, 0);
      check("bp_ready", ready_o, 0, 0);
      check("bp_x", $signed(x_o), 131072, 0);
    end
    check("bp_y", $signed(y_o), 196608, 4);
    check("bp_err", err_o, 0, 0);
    @(negedge clk_i);
    valid_i = 1'b0;
    pop("bp");
    repeat (20) @(posedge clk_i);
    #1;
    check("bp_no_ghost", valid_o, 0, 0);

    // ---------------- illegal mode: pass-through in one cycle, err flagged
    run_op(2'b11, 1'b1, 32'd1, 32'd2, 32'd3, lat);
    check("ill_lat", lat, 1, 0);
    check("ill_x", $signed(x_o), 1, 0);
    check("ill_y", $signed(y_o), 2, 0);
    check("ill_z", $signed(z_o), 3, 0);
    check("ill_err", err_o, 1, 0);
    pop("ill");

    // ---------------- reset during CALC
    @(negedge clk_i);
    mode_i = 2'b00; rotational_i = 1'b1; x_i = 32'h9B75; y_i = 32'h0; z_i = 32'hC910; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    #1;
    check("mid_rst_valid", valid_o, 0, 0);
    check("mid_rst_ready", ready_o, 1, 0);
    check("mid_rst_err",   err_o,   0, 0);
    check("mid_rst_x", $signed(x_o), 0, 0);
    check("mid_rst_z", $signed(z_o), 0, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    check("mid_rst_no_result", valid_o, 0, 0);
    run_op(2'b01, 1'b0, 32'h40000, 32'h20000, 32'h0, lat);
    check("post_rst_lat", lat, 16, 0);
    check("post_rst_z", $signed(z_o), 32768, 4);
    pop("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
